// File: rtl/rx_1t16_deser_align.sv
// rx_1t16_deser_align
//   1:16 serial deserializer with bit-slip word alignment. One serial bit is
//   shifted in per clock; every 16th bit a word is captured. Until SYNC_WORD
//   has been seen LOCK_CNT times in a row, each non-matching word causes a
//   one-bit slip of the word boundary (the bit counter holds for one cycle).
//   Once locked, words are passed through as data without comparison.
//
//   Optional feature (macro RX_DESER_PRBS_CHK_EN): self-synchronous PRBS7
//   (x^7+x^6+1) checker on locked words, accumulating a saturating bit-error
//   count. Without the macro prbs_err_cnt is tied to zero.
//
// Ports
//   clk           serial bit clock, rising edge
//   rstb          asynchronous active-low reset
//   din           serial data bit
//   realign       1-cycle pulse: drop lock, restart the search
//   dout          captured word, first-received bit in dout[0]
//   dout_valid    1-cycle strobe while dout holds a new word
//   align_lock    high while locked
//   slip_offset   total slips applied, modulo 16
//   prbs_err_cnt  PRBS7 bit-error count (zero when the checker is absent)

module rx_1t16_deser_align #(
  parameter int unsigned       WIDTH     = 16,
  parameter logic [WIDTH-1:0]  SYNC_WORD = 16'hFF00,
  parameter int unsigned       LOCK_CNT  = 4
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             din,
  input  logic             realign,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             align_lock,
  output logic [3:0]       slip_offset,
  output logic [15:0]      prbs_err_cnt
);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  localparam logic [3:0] LC       = 4'(LOCK_CNT);
  localparam logic [3:0] CNT_LAST = 4'(WIDTH - 1);

  logic [WIDTH-1:0] r_sr;
  logic [3:0]       r_cnt;
  logic             r_slip_pend;
  logic [3:0]       r_slip_off;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_match;
  logic [3:0]       w_match_nxt;
  logic             w_slip;
  logic             w_cap;
  logic [WIDTH-1:0] w_word;

  // The captured word includes the bit arriving on the capture edge.
  assign w_cap  = (r_cnt == CNT_LAST);
  assign w_word = {din, r_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_sr         <= '0;
      r_cnt        <= '0;
      r_slip_pend  <= 1'b0;
      r_slip_off   <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_state      <= ST_SEARCH;
      r_match      <= '0;
    end else begin
      r_sr <= w_word;
      // A slip is a one-cycle hold of the counter on the edge after the
      // capture, pushing the next boundary one bit later.
      if (!r_slip_pend) begin
        r_cnt <= r_cnt + 4'd1;
      end else begin
        r_slip_off <= r_slip_off + 4'd1;
      end
      r_slip_pend  <= w_slip;
      r_dout_valid <= w_cap;
      if (w_cap) begin
        r_dout <= w_word;
      end
      r_state <= w_state_nxt;
      r_match <= w_match_nxt;
    end
  end

  // Alignment FSM: evaluated once per captured word; realign has priority
  // and suppresses evaluation (and slipping) of a word captured alongside it.
  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match;
    w_slip      = 1'b0;
    if (realign) begin
      w_state_nxt = ST_SEARCH;
      w_match_nxt = '0;
    end else if (w_cap) begin
      case (r_state)
        ST_SEARCH: begin
          if (w_word == SYNC_WORD) begin
            w_match_nxt = 4'd1;
            w_state_nxt = (LC == 4'd1) ? ST_LOCKED : ST_VERIFY;
          end else begin
            w_slip = 1'b1;
          end
        end
        ST_VERIFY: begin
          if (w_word == SYNC_WORD) begin
            w_match_nxt = r_match + 4'd1;
            if ((r_match + 4'd1) == LC) begin
              w_state_nxt = ST_LOCKED;
            end
          end else begin
            w_state_nxt = ST_SEARCH;
            w_match_nxt = '0;
            w_slip      = 1'b1;
          end
        end
        ST_LOCKED: begin
          w_state_nxt = ST_LOCKED;
        end
        default: begin
          w_state_nxt = ST_SEARCH;
          w_match_nxt = '0;
        end
      endcase
    end
  end

  assign dout        = r_dout;
  assign dout_valid  = r_dout_valid;
  assign align_lock  = (r_state == ST_LOCKED);
  assign slip_offset = r_slip_off;

`ifdef RX_DESER_PRBS_CHK_EN
  logic [6:0]       r_prev7;
  logic             r_seeded;
  logic [15:0]      r_err_cnt;
  logic [WIDTH+6:0] w_ext;
  logic [WIDTH-1:0] w_err_vec;
  logic [4:0]       w_pop;
  logic [16:0]      w_sum;

  // w_ext[k] is stream bit (k-7) relative to the current word start, so the
  // recurrence b[n] = b[n-7] ^ b[n-6] spans the previous word's top 7 bits.
  assign w_ext = {w_word, r_prev7};

  always_comb begin
    w_err_vec = '0;
    w_pop     = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_err_vec[i] = w_ext[i+7] ^ w_ext[i] ^ w_ext[i+1];
      w_pop        = w_pop + {4'd0, w_err_vec[i]};
    end
  end

  assign w_sum = {1'b0, r_err_cnt} + {12'd0, w_pop};

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_prev7   <= '0;
      r_seeded  <= 1'b0;
      r_err_cnt <= '0;
    end else if (realign) begin
      r_seeded  <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_cap && (r_state == ST_LOCKED)) begin
      r_prev7  <= w_word[WIDTH-1:WIDTH-7];
      r_seeded <= 1'b1;
      // First locked word only seeds the history.
      if (r_seeded) begin
        r_err_cnt <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
      end
    end
  end

  assign prbs_err_cnt = r_err_cnt;
`else
  assign prbs_err_cnt = 16'h0000;
`endif

endmodule
